// File: rtl/membus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | membus_arbiter: round-robin N-client arbiter for one single-port memory  |
// | bus, with read-return tracking. Optional bus lock: MEMBUS_ARB_LOCK_EN.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module membus_arbiter #(
  parameter int NUM_CLIENTS  = 2,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CLIENTS-1:0]                 client_req,
  input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] client_addr,
  input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] client_wdata,
  input  logic [NUM_CLIENTS-1:0]                 client_we,
  input  logic [NUM_CLIENTS-1:0]                 client_lock,
  output logic [NUM_CLIENTS-1:0]                 client_gnt,
  output logic [NUM_CLIENTS-1:0]                 client_rvalid,
  output logic [DATA_WIDTH-1:0]                  client_rdata,
  output logic [ADDR_WIDTH-1:0]                  mem_address,
  output logic [DATA_WIDTH-1:0]                  mem_write_data,
  output logic                                   mem_write_enable,
  input  logic [DATA_WIDTH-1:0]                  mem_read_data
);

  localparam int c_ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [c_ID_W-1:0]                    r_last_gnt;
  logic [c_ID_W-1:0]                    w_winner;
  logic [c_ID_W-1:0]                    w_idx;
  logic                                 w_any;
  logic [NUM_CLIENTS-1:0]               w_eligible;
  logic [READ_LATENCY-1:0]              r_pipe_vld;
  logic [READ_LATENCY-1:0][c_ID_W-1:0]  r_pipe_id;

`ifdef MEMBUS_ARB_LOCK_EN
  logic              r_lock_active;
  logic [c_ID_W-1:0] r_lock_owner;
  logic              w_lock_hold;

  // Dropping client_lock releases the bus in the same cycle it is seen.
  assign w_lock_hold = r_lock_active && client_lock[r_lock_owner];

  always_comb begin
    w_eligible = client_req;
    if (w_lock_hold) begin
      w_eligible               = '0;
      w_eligible[r_lock_owner] = client_req[r_lock_owner];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_active <= 1'b0;
      r_lock_owner  <= '0;
    end else if (w_any && client_lock[w_winner]) begin
      r_lock_active <= 1'b1;
      r_lock_owner  <= w_winner;
    end else if (!w_lock_hold) begin
      r_lock_active <= 1'b0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^client_lock;
  assign w_eligible    = client_req;
`endif

  // Scan from farthest to nearest so the client right after last_gnt wins.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_idx    = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      w_idx = c_ID_W'((int'(r_last_gnt) + k) % NUM_CLIENTS);
      if (w_eligible[w_idx]) begin
        w_winner = w_idx;
        w_any    = 1'b1;
      end
    end
  end

  always_comb begin
    client_gnt       = '0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    if (w_any) begin
      client_gnt[w_winner] = 1'b1;
      mem_address          = client_addr[w_winner];
      mem_write_data       = client_wdata[w_winner];
      mem_write_enable     = client_we[w_winner];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= c_ID_W'(NUM_CLIENTS - 1);
    end else if (w_any) begin
      r_last_gnt <= w_winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_id  <= '0;
    end else begin
      r_pipe_vld[0] <= w_any && !client_we[w_winner];
      r_pipe_id[0]  <= w_winner;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_id[s]  <= r_pipe_id[s-1];
      end
    end
  end

  always_comb begin
    client_rvalid = '0;
    if (r_pipe_vld[READ_LATENCY-1]) begin
      client_rvalid[r_pipe_id[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign client_rdata = mem_read_data;

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_membus_arbiter: vector table plus read-return scoreboard for          |
// | membus_arbiter (4 clients, read latency 3). Rev 1.0                      |
// +--------------------------------------------------------------------------+
module tb_membus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RL = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         client_req;
  logic [N-1:0][AW-1:0] client_addr;
  logic [N-1:0][DW-1:0] client_wdata;
  logic [N-1:0]         client_we;
  logic [N-1:0]         client_lock;
  logic [N-1:0]         client_gnt;
  logic [N-1:0]         client_rvalid;
  logic [DW-1:0]        client_rdata;
  logic [AW-1:0]        mem_address;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_enable;
  logic [DW-1:0]        mem_read_data;

  membus_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .client_req      (client_req),
    .client_addr     (client_addr),
    .client_wdata    (client_wdata),
    .client_we       (client_we),
    .client_lock     (client_lock),
    .client_gnt      (client_gnt),
    .client_rvalid   (client_rvalid),
    .client_rdata    (client_rdata),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : 8'(a * 7 + 3);
  endfunction

  // Memory device: fixed RL-cycle read pipeline, read-before-write.
  logic [7:0]         mem [0:255];
  logic [RL-1:0][7:0] rd_pipe;
  logic               mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      rd_pipe <= '0;
    end else begin
      if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
      rd_pipe <= {rd_pipe[RL-2:0], mem[mem_address[7:0]]};
    end
  end
  assign mem_read_data = rd_pipe[RL-1];

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] shadow [0:255];
  int         cyc;
  int         n_cmp;
  int         n_err;

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] we;
    logic [N-1:0] gnt;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_bus(input logic [N-1:0] eg);
    int         w;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew;
    w  = -1;
    ea = '0;
    ed = '0;
    ew = 1'b0;
    chk("gnt", 32'(client_gnt), 32'(eg));
    for (int c = 0; c < N; c++) if (eg[c]) w = c;
    if (w >= 0) begin
      ea = client_addr[w];
      ed = client_wdata[w];
      ew = client_we[w];
    end
    chk("mem_address", 32'(mem_address), 32'(ea));
    chk("mem_write_data", 32'(mem_write_data), 32'(ed));
    chk("mem_write_enable", 32'(mem_write_enable), 32'(ew));
    if (w >= 0) begin
      if (ew) shadow[ea[7:0]] = ed;
      else    sb.push_back('{id: w, data: shadow[ea[7:0]], due: cyc + RL});
    end
  endtask

  task automatic check_rd();
    logic [N-1:0] er;
    logic [7:0]   ed;
    er = '0;
    ed = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      er[sb[0].id] = 1'b1;
      ed           = sb[0].data;
      void'(sb.pop_front());
    end
    chk("rvalid", 32'(client_rvalid), 32'(er));
    if (er != '0) chk("rdata", 32'(client_rdata), 32'(ed));
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_cycle(input logic [N-1:0] eg);
    @(negedge clk);
    check_bus(eg);
    check_rd();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    client_req  = '0;
    client_we   = '0;
    client_lock = '0;
    repeat (n) run_cycle('0);
  endtask

  task automatic access(input int c, input logic [15:0] a, input logic w, input logic [7:0] d);
    client_req      = '0;
    client_we       = '0;
    client_req[c]   = 1'b1;
    client_we[c]    = w;
    client_addr[c]  = a;
    client_wdata[c] = d;
  endtask

  logic [N-1:0] lock_exp [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    // Round-robin expectations from last_gnt=3 after reset.
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b1010, 4'b0010, 4'b0010};
    vecs[6]  = '{4'b1001, 4'b0000, 4'b1000};
    vecs[7]  = '{4'b1001, 4'b0000, 4'b0001};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b0100, 4'b0100, 4'b0100};
    vecs[10] = '{4'b0011, 4'b0000, 4'b0001};
    vecs[11] = '{4'b0011, 4'b0000, 4'b0010};
    vecs[12] = '{4'b1111, 4'b1111, 4'b0100};
    vecs[13] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[14] = '{4'b1100, 4'b0000, 4'b0100};
    vecs[15] = '{4'b1100, 4'b0000, 4'b1000};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0000};

`ifdef MEMBUS_ARB_LOCK_EN
    lock_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
`else
    lock_exp = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0001};
`endif

    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    n_cmp        = 0;
    n_err        = 0;
    cyc          = 0;
    rst          = 1'b1;
    mem_init     = 1'b1;
    client_req   = '0;
    client_addr  = '0;
    client_wdata = '0;
    client_we    = '0;
    client_lock  = '0;
    @(posedge clk);
    #1;
    mem_init = 1'b0;

    // Reset state: idle bus, no grants, no returns.
    run_cycle('0);
    run_cycle('0);
    rst = 1'b0;
    run_cycle('0);

    for (int i = 0; i < 17; i++) begin
      client_req = vecs[i].req;
      client_we  = vecs[i].we;
      for (int c = 0; c < N; c++) begin
        client_addr[c]  = 16'h0080 + 16'(i * 4 + c);
        client_wdata[c] = 8'(i * 16 + c + 1);
      end
      run_cycle(vecs[i].gnt);
    end
    idle(RL + 1);

    // Single read of the preloaded 0xA5 location.
    access(0, 16'h0010, 1'b0, 8'h00);
    run_cycle(4'b0001);
    idle(RL + 1);

    // Write then read-back through the memory.
    access(1, 16'h0042, 1'b1, 8'h3C);
    run_cycle(4'b0010);
    access(2, 16'h0042, 1'b0, 8'h00);
    run_cycle(4'b0100);
    idle(RL + 1);

    // Interleaved reads from clients 0 and 2.
    client_req      = 4'b0101;
    client_we       = '0;
    client_addr[0]  = 16'h0011;
    client_addr[2]  = 16'h0042;
    run_cycle(4'b0001);
    run_cycle(4'b0100);
    client_addr[0]  = 16'h0012;
    client_addr[2]  = 16'h0013;
    run_cycle(4'b0001);
    run_cycle(4'b0100);
    idle(RL + 1);

    // Reset one cycle after a read grant drops the pending return.
    access(3, 16'h0014, 1'b0, 8'h00);
    run_cycle(4'b1000);
    client_req = '0;
    rst        = 1'b1;
    sb.delete();
    run_cycle('0);
    run_cycle('0);
    rst         = 1'b0;
    client_req  = 4'b1111;
    client_we   = '0;
    for (int c = 0; c < N; c++) client_addr[c] = 16'h0020 + 16'(c);
    run_cycle(4'b0001);
    idle(RL + 1);

    // Client 2 locks for five accesses while client 0 keeps requesting.
    client_we      = '0;
    client_addr[0] = 16'h0030;
    client_addr[2] = 16'h0031;
    for (int k = 0; k < 7; k++) begin
      client_req  = (k < 5) ? 4'b0101 : 4'b0001;
      client_lock = (k < 6) ? 4'b0100 : 4'b0000;
      run_cycle(lock_exp[k]);
    end
    idle(RL + 1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/membus_arbiter.md
# membus_arbiter

Parametrised N-client arbiter that multiplexes several memory clients onto one single-port memory bus (address / write_data / write_enable / read_data) in front of the occupancy grid BRAM. Round-robin grants one access per cycle, returns read data to the issuing client after a fixed memory read latency, and optionally lets one client lock the bus for bulk transfers such as serial grid loading.

## Interface
- NUM_CLIENTS, 2: number of client ports, ≥2.
- ADDR_WIDTH, 16: memory address width.
- DATA_WIDTH, 8: memory data width.
- READ_LATENCY, 1: cycles from address presented to read_data valid, ≥1.
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- client_req  in  [NUM_CLIENTS-1:0]  per-client access request.
- client_addr  in  [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0]  per-client address.
- client_wdata  in  [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]  per-client write data.
- client_we  in  [NUM_CLIENTS-1:0]  1 = write, 0 = read.
- client_lock  in  [NUM_CLIENTS-1:0]  bus-lock request; ignored unless MEMBUS_ARB_LOCK_EN.
- client_gnt  out  [NUM_CLIENTS-1:0]  one-hot; access accepted this cycle.
- client_rvalid  out  [NUM_CLIENTS-1:0]  one-hot; read data for that client valid this cycle.
- client_rdata  out  DATA_WIDTH  memory read_data, broadcast to all clients.
- mem_address  out  ADDR_WIDTH  to memory.
- mem_write_data  out  DATA_WIDTH  to memory.
- mem_write_enable  out  1  to memory.
- mem_read_data  in  DATA_WIDTH  from memory.

## Operation
- Grant is combinational from client_req and registered pointer last_gnt: winner = first requesting index scanning last_gnt+1, last_gnt+2, … wrapping modulo NUM_CLIENTS.
- At most one client_gnt bit high per cycle; gnt implies req.
- Granted client's addr/wdata/we drive mem_* combinationally; access completes at the clock edge where gnt is high. Client holds signals stable until it sees gnt.
- No grant: mem_address=0, mem_write_data=0, mem_write_enable=0.
- On a grant, last_gnt ← winner index.
- Read tracking: shift register of READ_LATENCY stages, each {valid, client_id}; stage 0 loaded with {gnt && !we, winner}. client_rvalid[id]=1 when final stage valid. client_rdata = mem_read_data always.
- Writes produce gnt only, never rvalid.
- Back-to-back grants to any clients every cycle; reads fully pipelined, no stalls.

## Timing
- Reset (async assert): last_gnt=NUM_CLIENTS-1 (client 0 wins first tie), read pipeline cleared, lock owner cleared. Outputs during/after reset: client_gnt=0 unless req present, client_rvalid=0, mem_* idle values.
- Reset mid-read: pending reads are dropped; no rvalid ever appears for them.
- Read latency: gnt at cycle T → client_rvalid at T+READ_LATENCY.
- Grant latency: 0 cycles when uncontested; worst case NUM_CLIENTS-1 cycles under full contention (unlocked).
- Simultaneous requests: round-robin order strictly from last_gnt; a client re-requesting after its grant goes to the back.
- Requests from a client deasserted before gnt are simply never granted; no state kept.

## Configuration
- MEMBUS_ARB_LOCK_EN defined: registered lock_active + lock_owner. Granted client with client_lock=1 becomes owner; while lock_active, only owner can be granted (others wait, even if owner idles). Lock releases on the cycle owner deasserts client_lock (combinational release, round-robin resumes same cycle). Reset clears lock.
- Undefined: client_lock ignored, no lock state synthesised; pure round-robin.

## Test plan
- Single client 0 read addr 0x0010 (mem returns 0xA5, READ_LATENCY=1): gnt[0] at T, rvalid[0] with rdata 0xA5 at T+1, no other rvalid.
- NUM_CLIENTS=4, all req held reads: grants 0,1,2,3,0,… one per cycle; rvalid sequence identical, delayed READ_LATENCY.
- Client 1 write 0x0042←0x3C: mem_write_enable=1, mem_address=0x0042, mem_write_data=0x3C in gnt cycle; no rvalid; later read returns 0x3C.
- READ_LATENCY=3, alternating reads from clients 0 and 2: each rvalid lands on correct client exactly 3 cycles after its gnt.
- Reset asserted one cycle after a read gnt (READ_LATENCY=2): no rvalid afterward; first post-reset contested grant goes to client 0.
- MEMBUS_ARB_LOCK_EN, client 2 locks with req 5 cycles, client 0 requesting throughout: gnt[2] five cycles, gnt[0] 0 until client_lock[2] drops, then granted same cycle.
